bubble_sort_ctrl: RTL and testbench

//  Sequencer directly upstream of the 16-bit compare ALU. Accepts a DEPTH-word block over a

---
 rtl/bubblesort_pkg.sv | 15 +
 rtl/sort_regfile.sv | 38 +++
 rtl/bubble_sort_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bubblesort_pkg.sv
// Shared definitions for the bubble-sort sequencer and the compare-ALU bench:
// FSM state encoding and default block geometry.
package bubblesort_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CMP   = 2'd1,
    ST_SWAP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/sort_regfile.sv
// DEPTH x WIDTH register array for the bubble sorter.
// One write port (block load), two asynchronous read ports, and an atomic
// swap of the adjacent pair (swap_idx, swap_idx+1). Contents are not reset.
module sort_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             swap_i,
  input  logic [IDX_W-1:0] swap_idx_i,
  input  logic [IDX_W-1:0] ra_addr_i,
  output logic [WIDTH-1:0] ra_data_o,
  input  logic [IDX_W-1:0] rb_addr_i,
  output logic [WIDTH-1:0] rb_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] swap_nxt;

  assign swap_nxt  = swap_idx_i + IDX_W'(1);
  assign ra_data_o = mem_q[ra_addr_i];
  assign rb_data_o = mem_q[rb_addr_i];

  // Load writes one word; swap exchanges the adjacent pair in a single edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else if (swap_i) begin
      mem_q[swap_idx_i] <= mem_q[swap_nxt];
      mem_q[swap_nxt]   <= mem_q[swap_idx_i];
    end
  end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer feeding an external combinational 16-bit compare ALU.
// Loads a DEPTH-word block, sorts it ascending (unsigned) by driving the ALU
// with mem[j+1]/mem[j] and swapping on alu_lt, then streams the sorted block.
//
// Handshakes: a word moves on a stream only in a cycle where valid and ready
// are both high at the rising edge; valid never depends on ready, and
// out_valid/out_data hold steady while out_ready is low.
//
// Optional build macro SORT_EARLY_EXIT_EN: track whether a pass swapped and
// go straight to DRAIN after a pass with no swap. Ports are identical either way.
module bubble_sort_ctrl
  import bubblesort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic             alu_operation,
  input  logic             alu_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic [IDX_W-1:0] j_nxt;
  logic [IDX_W-1:0] ra_addr;
  logic [WIDTH-1:0] ra_data, rb_data;
  logic             rf_we, rf_swap;
  logic             advance;
  logic             pass_end, last_pass, early_exit;

`ifdef SORT_EARLY_EXIT_EN
  logic swapped_q, swapped_d;
  // A pass may end early only when it is finishing on a CMP with no swap seen.
  assign early_exit = (state_q == ST_CMP) && !swapped_q;
`else
  assign early_exit = 1'b0;
`endif

  assign j_nxt     = j_q + IDX_W'(1);
  assign pass_end  = (j_q == (LAST_PASS - pass_q));
  assign last_pass = (pass_q == LAST_PASS);

  // During DRAIN read port A walks the output index; otherwise it sits on mem[j].
  assign ra_addr = (state_q == ST_DRAIN) ? rd_idx_q : j_q;

  sort_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk        (clk),
    .we_i       (rf_we),
    .waddr_i    (wr_idx_q),
    .wdata_i    (in_data),
    .swap_i     (rf_swap),
    .swap_idx_i (j_q),
    .ra_addr_i  (ra_addr),
    .ra_data_o  (ra_data),
    .rb_addr_i  (j_nxt),
    .rb_data_o  (rb_data)
  );

  // Moore outputs decoded from the registered state; operands are zero outside CMP.
  assign in_ready      = (state_q == ST_LOAD);
  assign alu_operation = (state_q == ST_CMP);
  assign alu_op1       = (state_q == ST_CMP) ? rb_data : '0;
  assign alu_op2       = (state_q == ST_CMP) ? ra_data : '0;
  assign busy          = (state_q == ST_CMP) || (state_q == ST_SWAP);
  assign out_valid     = (state_q == ST_DRAIN);
  assign out_data      = (state_q == ST_DRAIN) ? ra_data : '0;
  assign out_last      = (state_q == ST_DRAIN) && (rd_idx_q == LAST_IDX);

  // State and counter registers; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      j_q       <= '0;
      pass_q    <= '0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  // Next-state, counter and regfile-control logic.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    j_d       = j_q;
    pass_d    = pass_q;
    rf_we     = 1'b0;
    rf_swap   = 1'b0;
    advance   = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          rf_we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d  = '0;
            j_d       = '0;
            pass_d    = '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
            state_d   = ST_CMP;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      ST_CMP: begin
        // Strict less-than: equal words stay in place, keeping the sort stable.
        if (alu_lt) begin
          state_d = ST_SWAP;
        end else begin
          advance = 1'b1;
        end
      end
      ST_SWAP: begin
        rf_swap   = 1'b1;
        advance   = 1'b1;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = 1'b1;
`endif
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = ST_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Step to the next compare, the next pass, or out to DRAIN.
    if (advance) begin
      if (pass_end) begin
        j_d = '0;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = 1'b0;
`endif
        if (last_pass || early_exit) begin
          pass_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          pass_d  = pass_q + IDX_W'(1);
          state_d = ST_CMP;
        end
      end else begin
        j_d     = j_nxt;
        state_d = ST_CMP;
      end
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: directed block vectors with hand-computed sorted
// output and busy-cycle counts, plus backpressure and mid-sort reset sequences.
module tb_bubble_sort_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic [0:7][W-1:0] din;
    logic [0:7][W-1:0] dexp;
    int                busy_exp;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] alu_op1;
  logic [W-1:0] alu_op2;
  logic         alu_operation;
  logic         alu_lt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int checks;
  int errors;
  int busy_cnt;
  vec_t vecs [4];

  bubble_sort_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_operation (alu_operation),
    .alu_lt        (alu_lt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy)
  );

  // External compare ALU: op1 < op2, unsigned, combinational.
  assign alu_lt = alu_operation && (alu_op1 < alu_op2);

  // Clock and busy-cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial busy_cnt = 0;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one block; returns just after the edge that took the last word.
  task automatic load_block(input logic [0:7][W-1:0] d);
    int n;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = d[i];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: got in_ready=0 expected in_ready=1 within 100 cycles");
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Waits for the sort, collects 8 words, and checks data, last flag and stalls.
  task automatic drain_block(input logic [0:7][W-1:0] dexp, input bit toggle);
    int got;
    int n;
    bit phase;
    bit stalled;
    logic [W-1:0] held;
    got = 0;
    n = 0;
    phase = 1'b1;
    stalled = 1'b0;
    held = '0;
    while (got < 8 && n < 400) begin
      @(posedge clk);
      #1;
      out_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      @(negedge clk);
      if (out_valid) begin
        if (stalled) check("stall_hold", 32'(out_data), 32'(held));
        if (out_ready) begin
          check($sformatf("data[%0d]", got), 32'(out_data), 32'(dexp[got]));
          check($sformatf("last[%0d]", got), 32'(out_last), 32'(got == 7));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      n++;
    end
    check("word_count", 32'(got), 32'd8);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_block_ready_valid", 32'({in_ready, out_valid}), 32'b10);
  endtask

  task automatic run_vec(input vec_t v, input bit toggle, input string tag);
    int start;
    start = busy_cnt;
    load_block(v.din);
    @(negedge clk);
    check({tag, "_in_ready_drop"}, 32'(in_ready), 32'd0);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    drain_block(v.dexp, toggle);
    check({tag, "_busy_cycles"}, 32'(busy_cnt - start), 32'(v.busy_exp));
  endtask

  initial begin
    int start;
    int n;
    checks = 0;
    errors = 0;

    // Mixed block: 14 inversions.
    vecs[0].din  = {16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4};
    vecs[0].dexp = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7, 16'd8, 16'd9};
    // Presorted: no swaps.
    vecs[1].din  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vecs[1].dexp = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    // Reverse: 28 inversions.
    vecs[2].din  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vecs[2].dexp = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    // Duplicates and full-scale values: 12 inversions.
    vecs[3].din  = {16'd4, 16'd4, 16'd0, 16'hFFFF, 16'd4, 16'd0, 16'hFFFF, 16'd1};
    vecs[3].dexp = {16'd0, 16'd0, 16'd1, 16'd4, 16'd4, 16'd4, 16'hFFFF, 16'hFFFF};
`ifdef SORT_EARLY_EXIT_EN
    vecs[0].busy_exp = 39;  // 25 CMP (passes of 7,6,5,4,3) + 14 SWAP
    vecs[1].busy_exp = 7;
    vecs[2].busy_exp = 56;
    vecs[3].busy_exp = 39;  // 27 CMP (passes of 7..2) + 12 SWAP
`else
    vecs[0].busy_exp = 42;
    vecs[1].busy_exp = 28;
    vecs[2].busy_exp = 56;
    vecs[3].busy_exp = 40;
`endif

    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_operation", 32'(alu_operation), 32'd0);
    check("rst_alu_op1", 32'(alu_op1), 32'd0);
    check("rst_alu_op2", 32'(alu_op2), 32'd0);

    for (int k = 0; k < 4; k++) begin
      run_vec(vecs[k], 1'b0, $sformatf("vec%0d", k));
    end

    // Backpressure: out_ready alternates 1,0 throughout the drain.
    run_vec(vecs[0], 1'b1, "toggle");

    // Reset after 10 busy cycles of a reverse block, then sort a fresh block.
    start = busy_cnt;
    load_block(vecs[2].din);
    n = 0;
    while ((busy_cnt - start) < 10 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midsort_reached", 32'(busy_cnt - start >= 10), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    run_vec(vecs[3], 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
